// File: rtl/eq_reg_bank.sv
// rtl/eq_reg_bank.sv - equalizer gain register bank with shadow/active copies
// Shadow registers take I2C writes; the active copy loads atomically on a sample tick.
module eq_reg_bank #(
  parameter int         NUM_BANDS  = 8,
  parameter int         GAIN_W     = 8,
  parameter logic [7:0] UNITY_GAIN = 8'h40,
  parameter logic [7:0] GAIN_MAX   = 8'hC0,
  parameter logic [7:0] BAND_BASE  = 8'h10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  reg_addr,
  input  logic [7:0]                  reg_data,
  input  logic                        reg_we,
  input  logic [7:0]                  rd_addr,
  output logic [7:0]                  rd_data,
  input  logic                        sample_tick,
  output logic [NUM_BANDS*GAIN_W-1:0] band_gain,
  output logic [GAIN_W-1:0]           master_gain,
  output logic                        bypass,
  output logic                        mute,
  output logic                        coeff_update,
  output logic                        err_flag
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_MASTER = 8'h02;

  logic              we_q;
  logic              wr;
  logic              commit;

  logic [GAIN_W-1:0] sh_band [NUM_BANDS];
  logic [GAIN_W-1:0] act_band [NUM_BANDS];
  logic [GAIN_W-1:0] sh_master, act_master;
  logic              sh_bypass, sh_mute, act_bypass, act_mute;
  logic              pending, addr_err, clamp;

  logic [GAIN_W-1:0] sh_band_n [NUM_BANDS];
  logic [GAIN_W-1:0] sh_master_n;
  logic              sh_bypass_n, sh_mute_n;
  logic              pending_n, addr_err_n, clamp_n;
  logic [GAIN_W-1:0] gain_val;
  logic              is_band;
  int                wr_off;
  int                rd_off;
  logic [7:0]        rd_next;

  assign wr     = reg_we & ~we_q;
  assign commit = sample_tick & pending;

  // Shadow/status next state; a commit clears pending before a same-cycle COMMIT write re-sets it.
  always_comb begin
    sh_band_n   = sh_band;
    sh_master_n = sh_master;
    sh_bypass_n = sh_bypass;
    sh_mute_n   = sh_mute;
    pending_n   = pending & ~commit;
    addr_err_n  = addr_err;
    clamp_n     = clamp;
    wr_off      = int'(reg_addr) - int'(BAND_BASE);
    is_band     = (wr_off >= 0) && (wr_off < NUM_BANDS);
    gain_val    = (reg_data > GAIN_MAX) ? GAIN_MAX : reg_data;
    if (wr) begin
      if (reg_addr == ADDR_CTRL) begin
        if (reg_data[7]) begin
          for (int i = 0; i < NUM_BANDS; i++) sh_band_n[i] = UNITY_GAIN;
          sh_master_n = UNITY_GAIN;
          sh_bypass_n = 1'b0;
          sh_mute_n   = 1'b0;
          pending_n   = 1'b0;
          addr_err_n  = 1'b0;
          clamp_n     = 1'b0;
        end else begin
          sh_bypass_n = reg_data[1];
          sh_mute_n   = reg_data[2];
        end
        if (reg_data[0]) pending_n = 1'b1;
      end else if (reg_addr == ADDR_STATUS) begin
        if (reg_data[1]) addr_err_n = 1'b0;
        if (reg_data[2]) clamp_n = 1'b0;
      end else if (reg_addr == ADDR_MASTER || is_band) begin
        if (reg_data > GAIN_MAX) clamp_n = 1'b1;
        if (reg_addr == ADDR_MASTER) sh_master_n = gain_val;
        for (int i = 0; i < NUM_BANDS; i++)
          if (is_band && wr_off == i) sh_band_n[i] = gain_val;
      end else begin
        addr_err_n = 1'b1;
      end
    end
  end

  // Read decode looks at current state, so same-cycle writes are not visible.
  always_comb begin
    rd_next = 8'h00;
    rd_off  = int'(rd_addr) - int'(BAND_BASE);
    case (rd_addr)
      ADDR_CTRL:   rd_next = {5'b0, sh_mute, sh_bypass, 1'b0};
      ADDR_STATUS: rd_next = {5'b0, clamp, addr_err, pending};
      ADDR_MASTER: rd_next = sh_master;
      default: begin
        for (int i = 0; i < NUM_BANDS; i++)
          if (rd_off == i) rd_next = sh_band[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      sh_master    <= UNITY_GAIN;
      act_master   <= UNITY_GAIN;
      sh_bypass    <= 1'b0;
      sh_mute      <= 1'b0;
      act_bypass   <= 1'b0;
      act_mute     <= 1'b0;
      pending      <= 1'b0;
      addr_err     <= 1'b0;
      clamp        <= 1'b0;
      err_flag     <= 1'b0;
      coeff_update <= 1'b0;
      rd_data      <= 8'h00;
      for (int i = 0; i < NUM_BANDS; i++) begin
        sh_band[i]  <= UNITY_GAIN;
        act_band[i] <= UNITY_GAIN;
      end
    end else begin
      we_q         <= reg_we;
      sh_band      <= sh_band_n;
      sh_master    <= sh_master_n;
      sh_bypass    <= sh_bypass_n;
      sh_mute      <= sh_mute_n;
      pending      <= pending_n;
      addr_err     <= addr_err_n;
      clamp        <= clamp_n;
      err_flag     <= addr_err_n | clamp_n;
      coeff_update <= commit;
      rd_data      <= rd_next;
      if (commit) begin
        act_band   <= sh_band;
        act_master <= sh_master;
        act_bypass <= sh_bypass;
        act_mute   <= sh_mute;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band_out
    assign band_gain[g*GAIN_W +: GAIN_W] = act_band[g];
  end

  assign master_gain = act_master;
  assign bypass      = act_bypass;
  assign mute        = act_mute;

endmodule
